// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit controller with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, then a sign-fix cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes and MFHI/MFLO reads served directly
// RUN   | 32 iteration cycles on the 64-bit accumulator
// FIX   | sign correction, done pulse, HI/LO written at end of cycle
module mdu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_div,
    input  logic        op_signed,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mf_req,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opB;
    logic        opDiv;
    logic        negRes;
    logic        negRem;

    logic [31:0] magA;
    logic [31:0] magB;
    logic [32:0] mulSum;
    logic [32:0] divTrial;
    logic        divGe;
    logic [31:0] divSub;
    logic [63:0] accNext;
    logic [63:0] prodFix;
    logic [31:0] quoFix;
    logic [31:0] remFix;

    always_comb begin
        magA = (op_signed && rs_data[31]) ? -rs_data : rs_data;
        magB = (op_signed && rt_data[31]) ? -rt_data : rt_data;

        mulSum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opB} : 33'd0);

        // Partial remainder may need 33 bits after the shift; the subtracted
        // value is always below the divisor, so 32 bits of it suffice.
        divTrial = acc[63:31];
        divGe    = divTrial >= {1'b0, opB};
        divSub   = divTrial[31:0] - opB;

        accNext = {mulSum, acc[31:1]};
        if (opDiv) begin
            accNext = divGe ? {divSub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
        end

        prodFix = negRes ? -acc : acc;
        quoFix  = negRes ? -acc[31:0] : acc[31:0];
        remFix  = negRem ? -acc[63:32] : acc[63:32];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            acc    <= 64'd0;
            opB    <= 32'd0;
            opDiv  <= 1'b0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        opDiv <= op_div;
                        cnt   <= 6'd0;
                        if (op_div && (rt_data == 32'd0)) begin
                            // Divide by zero: skip iterations, FIX passes acc through unsigned
                            acc    <= {rs_data, 32'hFFFF_FFFF};
                            opB    <= 32'd0;
                            negRes <= 1'b0;
                            negRem <= 1'b0;
                            state  <= FIX;
                        end else begin
                            acc    <= {32'd0, magA};
                            opB    <= magB;
                            negRes <= op_signed & (rs_data[31] ^ rt_data[31]);
                            negRem <= op_signed & rs_data[31];
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= accNext;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= FIX;
                end
                FIX: begin
                    if (opDiv) begin
                        hi <= remFix;
                        lo <= quoFix;
                    end else begin
                        hi <= prodFix[63:32];
                        lo <= prodFix[31:0];
                    end
                    cnt   <= 6'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FIX);
    assign stall_req = busy & (start | mf_req | hi_we | lo_we);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios with literal results
// plus randomized traffic compared every cycle against a behavioural model.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op_div;
    logic        op_signed;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mf_req;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_div   (op_div),
        .op_signed(op_signed),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .mf_req   (mf_req),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .stall_req(stall_req),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of an operation as {hi, lo}, from plain 64-bit arithmetic.
    function automatic logic [63:0] refCalc(input logic d, input logic s,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] qv, rv, pv;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (!d) begin
            p  = sa * sb;
            pv = p;
            return pv;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Model: cycles remaining until the operation retires (0 = idle).
    int          mRem = 0;
    logic [31:0] mHi  = 32'd0;
    logic [31:0] mLo  = 32'd0;
    logic [63:0] mRes = 64'd0;

    always @(posedge clk) begin
        if (reset) begin
            mRem = 0;
            mHi  = 32'd0;
            mLo  = 32'd0;
        end else if (mRem == 0) begin
            if (hi_we) mHi = wdata;
            if (lo_we) mLo = wdata;
            if (start) begin
                mRes = refCalc(op_div, op_signed, rs_data, rt_data);
                mRem = (op_div && rt_data == 32'd0) ? 1 : 33;
            end
        end else begin
            mRem = mRem - 1;
            if (mRem == 0) begin
                mHi = mRes[63:32];
                mLo = mRes[31:0];
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            check("model_busy", {63'd0, busy}, {63'd0, mRem != 0});
            check("model_done", {63'd0, done}, {63'd0, mRem == 1});
            check("model_stall", {63'd0, stall_req},
                  {63'd0, (mRem != 0) && (start || mf_req || hi_we || lo_we)});
            check("model_hi", {32'd0, hi}, {32'd0, mHi});
            check("model_lo", {32'd0, lo}, {32'd0, mLo});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        op_div    = d;
        op_signed = s;
        rs_data   = a;
        rt_data   = b;
        tick();
        start = 1'b0;
    endtask

    // Called in cycle k+1; returns n such that done is seen in cycle k+n.
    task automatic waitDone(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runOp(input string name, input logic d, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input int expLat, input logic [31:0] expHi, input logic [31:0] expLo);
        int lat;
        issue(d, s, a, b);
        waitDone(lat);
        check({name, "_latency"}, lat, expLat);
        tick();
        @(negedge clk);
        check({name, "_hi"}, {32'd0, hi}, {32'd0, expHi});
        check({name, "_lo"}, {32'd0, lo}, {32'd0, expLo});
        check({name, "_idle"}, {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int sawDone;

        reset = 1'b1; start = 1'b0; op_div = 1'b0; op_signed = 1'b0;
        rs_data = 32'd0; rt_data = 32'd0; mf_req = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        checkEn = 1'b1;

        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #1;

        check("pin_mult", refCalc(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        check("pin_div", refCalc(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("pin_ovf", refCalc(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        runOp("multu_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 33, 32'd1, 32'hFFFF_FFFE);
        runOp("div_neg", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("mult_neg", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        runOp("divu_zero", 1'b1, 1'b0, 32'd100, 32'd0, 1, 32'd100, 32'hFFFF_FFFF);
        runOp("div_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
        runOp("divs_zero", 1'b1, 1'b1, 32'hFFFF_FF00, 32'd0, 1, 32'hFFFF_FF00, 32'hFFFF_FFFF);

        // mf_req plus a second start arriving at k+10 of a multiply
        issue(1'b0, 1'b0, 32'd6, 32'd7);
        repeat (9) tick();
        mf_req = 1'b1; start = 1'b1; op_div = 1'b1; op_signed = 1'b0;
        rs_data = 32'd50; rt_data = 32'd7;
        for (int c = 10; c <= 33; c++) begin
            @(negedge clk);
            check("stall_held", {63'd0, stall_req}, 64'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("stall_release", {63'd0, stall_req}, 64'd0);
        check("first_result", {hi, lo}, {32'd0, 32'd42});
        @(posedge clk);
        #1;
        start = 1'b0; mf_req = 1'b0;
        waitDone(lat);
        check("second_latency", lat, 33);
        tick();
        @(negedge clk);
        check("second_result", {hi, lo}, {32'd1, 32'd7});
        @(posedge clk);
        #1;

        // reset in the middle of a divide
        issue(1'b1, 1'b0, 32'd1000, 32'd3);
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        sawDone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) sawDone++;
        end
        check("abort_no_done", sawDone, 0);
        @(posedge clk);
        #1;

        // MTHI together with a MULTU start
        hi_we = 1'b1; wdata = 32'h1234;
        issue(1'b0, 1'b0, 32'd3, 32'd4);
        hi_we = 1'b0;
        @(negedge clk);
        check("mthi_immediate", {32'd0, hi}, 64'h1234);
        @(posedge clk);
        #1;
        waitDone(lat);
        check("mthi_latency", lat, 32);
        tick();
        @(negedge clk);
        check("mthi_overwrite", {hi, lo}, {32'd0, 32'd12});
        @(posedge clk);
        #1;

        for (int c = 0; c < 1500; c++) begin
            start     = ($urandom_range(0, 7) == 0);
            op_div    = $urandom_range(0, 1);
            op_signed = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0: rt_data = 32'd0;
                1: rt_data = 32'hFFFF_FFFF;
                2: rt_data = $urandom_range(1, 20);
                default: rt_data = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rs_data = 32'h8000_0000;
                1: rs_data = $urandom_range(0, 1000);
                default: rs_data = $urandom;
            endcase
            mf_req = ($urandom_range(0, 3) == 0);
            hi_we  = ($urandom_range(0, 15) == 0);
            lo_we  = ($urandom_range(0, 15) == 0);
            wdata  = $urandom;
            reset  = ($urandom_range(0, 299) == 0);
            tick();
        end
        start = 1'b0; mf_req = 1'b0; hi_we = 1'b0; lo_we = 1'b0; reset = 1'b0;
        repeat (40) tick();

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
